// File: rtl/pkt_comm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkt_comm_pkg
// Description : Shared definitions for the pkt_comm input path: packet type
//               codes, frame geometry, status bit positions, and dispatcher
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pkt_comm_pkg;

    // Packet type codes (sink index = type - 1)
    localparam int PKT_TYPE_WORD_LIST  = 1;
    localparam int PKT_TYPE_WORD_GEN   = 2;
    localparam int PKT_TYPE_CMP_CONFIG = 3;

    // Frame geometry, bytes
    localparam int PKT_HDR_LEN  = 10;
    localparam int PKT_CSUM_LEN = 4;

    // pkt_comm_status bit positions
    localparam int ST_BIT_VER       = 0;
    localparam int ST_BIT_TYPE      = 1;
    localparam int ST_BIT_LEN       = 2;
    localparam int ST_BIT_HDR_CSUM  = 3;
    localparam int ST_BIT_BODY_CSUM = 4;

    // Dispatcher FSM states
    typedef enum logic [2:0] {
        ST_HDR       = 3'd0,
        ST_HDR_CSUM  = 3'd1,
        ST_BODY      = 3'd2,
        ST_BODY_CSUM = 3'd3,
        ST_ERROR     = 3'd4
    } pkt_state_e;

endpackage
`default_nettype wire

// File: rtl/pkt_comm_dispatch_checksum.sv
`default_nettype none
// ============================================================================
// Module      : pkt_checksum32
// Description : Byte-serial accumulator of 32-bit little-endian words.
//               i_add shifts a byte into the current word; a full word is
//               added to the running sum. i_flush adds a partial (zero-padded)
//               word. i_clear restarts the accumulation. o_sum is the raw
//               sum; the caller inverts it for comparison.
//               Built only when PKT_COMM_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef PKT_COMM_CHECKSUM_EN
module pkt_checksum32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_add,
    input  logic        i_flush,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_sum
);

    logic [31:0] r_sum;
    logic [31:0] r_word;
    logic [1:0]  r_pos;
    logic [31:0] w_word_nxt;

    // Merge the incoming byte into its little-endian lane of the current word
    always_comb begin
        w_word_nxt = r_word;
        case (r_pos)
            2'd0:    w_word_nxt[7:0]   = i_byte;
            2'd1:    w_word_nxt[15:8]  = i_byte;
            2'd2:    w_word_nxt[23:16] = i_byte;
            default: w_word_nxt[31:24] = i_byte;
        endcase
    end

    // Word assembly and running sum; clear wins over add and flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= 32'd0;
            r_word <= 32'd0;
            r_pos  <= 2'd0;
        end else if (i_clear) begin
            r_sum  <= 32'd0;
            r_word <= 32'd0;
            r_pos  <= 2'd0;
        end else if (i_add) begin
            if (r_pos == 2'd3) begin
                r_sum  <= r_sum + w_word_nxt;
                r_word <= 32'd0;
                r_pos  <= 2'd0;
            end else begin
                r_word <= w_word_nxt;
                r_pos  <= r_pos + 2'd1;
            end
        end else if (i_flush) begin
            r_sum  <= r_sum + r_word;
            r_word <= 32'd0;
            r_pos  <= 2'd0;
        end
    end

    assign o_sum = r_sum;

endmodule
`endif
`default_nettype wire

// File: rtl/pkt_comm_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : pkt_comm_dispatch
// Description : Front-end controller of the pkt_comm input path. Parses and
//               validates packet headers from a FWFT byte FIFO and routes
//               body bytes to one of PKT_MAX_TYPE sinks with per-sink flow
//               control. Sticky error status is reported to the host.
//               Optional macro PKT_COMM_CHECKSUM_EN enables header and body
//               checksum verification (otherwise checksum bytes are skipped).
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_comm_dispatch
    import pkt_comm_pkg::*;
#(
    parameter int PKT_VERSION  = 2,
    parameter int PKT_MAX_TYPE = 3,
    parameter int PKT_MAX_LEN  = 65536
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [7:0]              din,
    input  logic                    empty,
    output logic                    rd_en,
    output logic [7:0]              dout,
    output logic [PKT_MAX_TYPE-1:0] wr_en,
    input  logic [PKT_MAX_TYPE-1:0] full,
    output logic                    pkt_start,
    output logic [7:0]              pkt_type,
    output logic [15:0]             pkt_id,
    output logic [23:0]             pkt_len,
    output logic                    pkt_end,
    output logic                    pkt_bad,
    output logic [7:0]              pkt_comm_status,
    output logic                    error
);

    pkt_state_e              r_state;
    logic [23:0]             r_cnt;
    logic [7:0]              r_hdr_ver;
    logic [7:0]              r_hdr_type;
    logic [23:0]             r_hdr_len;
    logic [7:0]              r_hdr_id0;
    logic [7:0]              r_hdr_id1;
    logic [PKT_MAX_TYPE-1:0] r_sel;

    logic [7:0]              r_dout;
    logic [PKT_MAX_TYPE-1:0] r_wr_en;
    logic                    r_pkt_start;
    logic [7:0]              r_pkt_type;
    logic [15:0]             r_pkt_id;
    logic [23:0]             r_pkt_len;
    logic                    r_pkt_end;
    logic                    r_pkt_bad;
    logic [7:0]              r_status;
    logic                    r_error;

    logic                    w_rd;
    logic                    w_full_sel;
    logic                    w_hdr_last;
    logic                    w_csum_last;
    logic                    w_body_last;
    logic                    w_ver_bad;
    logic                    w_type_bad;
    logic                    w_len_bad;
    logic                    w_hdr_csum_ok;
    logic                    w_body_csum_ok;
    logic [PKT_MAX_TYPE-1:0] w_hdr_sel;

    // One-hot sink select decoded from the header type byte
    for (genvar g = 0; g < PKT_MAX_TYPE; g++) begin : g_sel
        assign w_hdr_sel[g] = (r_hdr_type == 8'(g + 1));
    end

    assign w_full_sel  = |(full & r_sel);
    assign w_hdr_last  = (r_cnt == 24'(PKT_HDR_LEN - 1));
    assign w_csum_last = (r_cnt == 24'(PKT_CSUM_LEN - 1));
    assign w_body_last = (r_cnt == (r_pkt_len - 24'd1));

    // Header field checks, evaluated while the final header byte is read
    assign w_ver_bad  = (r_hdr_ver != 8'(PKT_VERSION));
    assign w_type_bad = (r_hdr_type < 8'(PKT_TYPE_WORD_LIST)) ||
                        (r_hdr_type > 8'(PKT_MAX_TYPE));
    assign w_len_bad  = (r_hdr_len == 24'd0) ||
                        (r_hdr_len > 24'(PKT_MAX_LEN));

    // FIFO pop: body reads also wait on the selected sink; nothing while in reset or ERROR
    always_comb begin
        w_rd = 1'b0;
        if (RST_N) begin
            case (r_state)
                ST_HDR, ST_HDR_CSUM, ST_BODY_CSUM: w_rd = !empty;
                ST_BODY:                           w_rd = !empty && !w_full_sel;
                default:                           w_rd = 1'b0;
            endcase
        end
    end

`ifdef PKT_COMM_CHECKSUM_EN
    logic [23:0] r_csum_b;
    logic [31:0] w_sum;
    logic        w_in_csum;
    logic        w_ck_add;
    logic        w_ck_flush;
    logic        w_ck_clear;

    assign w_in_csum  = (r_state == ST_HDR_CSUM) || (r_state == ST_BODY_CSUM);
    assign w_ck_add   = w_rd && ((r_state == ST_HDR) || (r_state == ST_BODY));
    // Pad out the trailing partial word as soon as the first checksum byte arrives
    assign w_ck_flush = w_rd && w_in_csum && (r_cnt == 24'd0);
    // Restart after each checksum field so header and body sums are independent
    assign w_ck_clear = w_rd && w_in_csum && w_csum_last;

    pkt_checksum32 u_csum (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_clear (w_ck_clear),
        .i_add   (w_ck_add),
        .i_flush (w_ck_flush),
        .i_byte  (din),
        .o_sum   (w_sum)
    );

    // Hold the first three received checksum bytes; the fourth is live on din
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_csum_b <= 24'd0;
        end else if (w_rd && w_in_csum) begin
            case (r_cnt[1:0])
                2'd0:    r_csum_b[7:0]   <= din;
                2'd1:    r_csum_b[15:8]  <= din;
                2'd2:    r_csum_b[23:16] <= din;
                default: r_csum_b        <= r_csum_b;
            endcase
        end
    end

    assign w_hdr_csum_ok  = ((~w_sum) == {din, r_csum_b});
    assign w_body_csum_ok = ((~w_sum) == {din, r_csum_b});
`else
    assign w_hdr_csum_ok  = 1'b1;
    assign w_body_csum_ok = 1'b1;
`endif

    // Main parser FSM with registered sink write path, pulses and sticky status
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_HDR;
            r_cnt       <= 24'd0;
            r_hdr_ver   <= 8'd0;
            r_hdr_type  <= 8'd0;
            r_hdr_len   <= 24'd0;
            r_hdr_id0   <= 8'd0;
            r_hdr_id1   <= 8'd0;
            r_sel       <= '0;
            r_dout      <= 8'd0;
            r_wr_en     <= '0;
            r_pkt_start <= 1'b0;
            r_pkt_type  <= 8'd0;
            r_pkt_id    <= 16'd0;
            r_pkt_len   <= 24'd0;
            r_pkt_end   <= 1'b0;
            r_pkt_bad   <= 1'b0;
            r_status    <= 8'd0;
            r_error     <= 1'b0;
        end else begin
            r_wr_en     <= '0;
            r_pkt_start <= 1'b0;
            r_pkt_end   <= 1'b0;
            r_pkt_bad   <= 1'b0;
            case (r_state)
                ST_HDR: begin
                    if (w_rd) begin
                        case (r_cnt[3:0])
                            4'd0:    r_hdr_ver        <= din;
                            4'd1:    r_hdr_type       <= din;
                            4'd4:    r_hdr_len[7:0]   <= din;
                            4'd5:    r_hdr_len[15:8]  <= din;
                            4'd6:    r_hdr_len[23:16] <= din;
                            4'd8:    r_hdr_id0        <= din;
                            4'd9:    r_hdr_id1        <= din;
                            default: r_hdr_id1        <= r_hdr_id1;
                        endcase
                        if (w_hdr_last) begin
                            r_cnt <= 24'd0;
                            r_status[ST_BIT_VER]  <= r_status[ST_BIT_VER]  | w_ver_bad;
                            r_status[ST_BIT_TYPE] <= r_status[ST_BIT_TYPE] | w_type_bad;
                            r_status[ST_BIT_LEN]  <= r_status[ST_BIT_LEN]  | w_len_bad;
                            if (w_ver_bad || w_type_bad || w_len_bad) begin
                                r_state <= ST_ERROR;
                                r_error <= 1'b1;
                            end else begin
                                r_state <= ST_HDR_CSUM;
                            end
                        end else begin
                            r_cnt <= r_cnt + 24'd1;
                        end
                    end
                end
                ST_HDR_CSUM: begin
                    if (w_rd) begin
                        if (w_csum_last) begin
                            r_cnt <= 24'd0;
                            if (!w_hdr_csum_ok) begin
                                r_status[ST_BIT_HDR_CSUM] <= 1'b1;
                                r_state <= ST_ERROR;
                                r_error <= 1'b1;
                            end else begin
                                r_pkt_type  <= r_hdr_type;
                                r_pkt_id    <= {r_hdr_id1, r_hdr_id0};
                                r_pkt_len   <= r_hdr_len;
                                r_sel       <= w_hdr_sel;
                                r_pkt_start <= 1'b1;
                                r_state     <= ST_BODY;
                            end
                        end else begin
                            r_cnt <= r_cnt + 24'd1;
                        end
                    end
                end
                ST_BODY: begin
                    if (w_rd) begin
                        r_wr_en <= r_sel;
                        r_dout  <= din;
                        if (w_body_last) begin
                            r_cnt   <= 24'd0;
                            r_state <= ST_BODY_CSUM;
                        end else begin
                            r_cnt <= r_cnt + 24'd1;
                        end
                    end
                end
                ST_BODY_CSUM: begin
                    if (w_rd) begin
                        if (w_csum_last) begin
                            r_cnt     <= 24'd0;
                            r_pkt_end <= 1'b1;
                            r_state   <= ST_HDR;
                            if (!w_body_csum_ok) begin
                                r_pkt_bad <= 1'b1;
                                r_status[ST_BIT_BODY_CSUM] <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 24'd1;
                        end
                    end
                end
                ST_ERROR: begin
                    r_state <= ST_ERROR;
                end
                default: begin
                    r_state <= ST_ERROR;
                    r_error <= 1'b1;
                end
            endcase
        end
    end

    assign rd_en           = w_rd;
    assign dout            = r_dout;
    assign wr_en           = r_wr_en;
    assign pkt_start       = r_pkt_start;
    assign pkt_type        = r_pkt_type;
    assign pkt_id          = r_pkt_id;
    assign pkt_len         = r_pkt_len;
    assign pkt_end         = r_pkt_end;
    assign pkt_bad         = r_pkt_bad;
    assign pkt_comm_status = r_status;
    assign error           = r_error;

endmodule
`default_nettype wire

// File: tb/tb_pkt_comm_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_comm_dispatch
// Description : Self-checking bench for pkt_comm_dispatch. A byte-queue FIFO
//               model feeds the DUT; sink writes and packet pulses are logged
//               and compared against expectations built from whole packets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_comm_dispatch;
    import pkt_comm_pkg::*;

`ifdef PKT_COMM_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef byte unsigned bq_t[$];

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [7:0]  din = 8'h00;
    logic        empty = 1'b1;
    logic        rd_en;
    logic [7:0]  dout;
    logic [2:0]  wr_en;
    logic [2:0]  full = 3'b000;
    logic        pkt_start;
    logic [7:0]  pkt_type;
    logic [15:0] pkt_id;
    logic [23:0] pkt_len;
    logic        pkt_end;
    logic        pkt_bad;
    logic [7:0]  pkt_comm_status;
    logic        error;

    pkt_comm_dispatch dut (
        .CLK(CLK), .RST_N(RST_N), .din(din), .empty(empty), .rd_en(rd_en),
        .dout(dout), .wr_en(wr_en), .full(full), .pkt_start(pkt_start),
        .pkt_type(pkt_type), .pkt_id(pkt_id), .pkt_len(pkt_len),
        .pkt_end(pkt_end), .pkt_bad(pkt_bad), .pkt_comm_status(pkt_comm_status),
        .error(error)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    byte unsigned fifo[$];
    int           gap_pct    = 0;
    bit           full_rand  = 1'b0;
    logic [2:0]   full_force = 3'b000;
    bit           pend_pop   = 1'b0;
    bit           in_win     = 1'b0;
    int           win_writes = 0;

    int           got_sink[$];
    byte unsigned got_byte[$];
    logic [7:0]   got_type[$];
    logic [15:0]  got_id[$];
    logic [23:0]  got_len[$];
    bit           got_bad[$];

    int           exp_sink[$];
    byte unsigned exp_byte[$];
    logic [7:0]   exp_type[$];
    logic [15:0]  exp_id[$];
    logic [23:0]  exp_len[$];
    bit           exp_bad[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor (outputs registered at posedge, observed at negedge), FIFO model and input driver
    always begin
        @(negedge CLK);
        if (wr_en != 3'b000) begin
            total++;
            if ($countones(wr_en) != 1 || (wr_en & full) != 3'b000) begin
                bad++;
                $display("FAIL wr_beat actual wr_en=%b full=%b required one-hot write to a non-full sink", wr_en, full);
            end
            for (int t = 0; t < 3; t++)
                if (wr_en[t]) begin
                    got_sink.push_back(t);
                    got_byte.push_back(dout);
                end
            if (in_win && wr_en[1]) win_writes++;
        end
        if (pkt_start) begin
            got_type.push_back(pkt_type);
            got_id.push_back(pkt_id);
            got_len.push_back(pkt_len);
        end
        if (pkt_end) got_bad.push_back(pkt_bad);
        else if (pkt_bad) begin
            total++;
            bad++;
            $display("FAIL stray_pkt_bad actual=1 required=0 (without pkt_end)");
        end
        if (pend_pop && fifo.size() > 0) void'(fifo.pop_front());
        for (int t = 0; t < 3; t++)
            full[t] = full_force[t] | (full_rand && ($urandom_range(0, 4) == 0));
        empty = (fifo.size() == 0) || (gap_pct > 0 && $urandom_range(0, 99) < gap_pct);
        din   = (fifo.size() > 0) ? fifo[0] : 8'h00;
        #4;
        pend_pop = rd_en;
    end

    // Reference checksum: inverted 32-bit sum of zero-padded little-endian words
    function automatic logic [31:0] ref_csum(input bq_t b);
        logic [31:0] s;
        logic [31:0] w;
        s = 32'd0;
        for (int i = 0; i < b.size(); i += 4) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++)
                if (i + k < b.size()) w = w | (32'(b[i+k]) << (8 * k));
            s = s + w;
        end
        return ~s;
    endfunction

    function automatic bq_t rand_body(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic push_pkt(input logic [7:0] ver, input logic [7:0] typ, input logic [23:0] len,
                            input logic [15:0] id, input bq_t body, input bit hbad, input bit bbad);
        bq_t h;
        logic [31:0] c;
        h.push_back(ver);        h.push_back(typ);
        h.push_back(8'h00);      h.push_back(8'h00);
        h.push_back(len[7:0]);   h.push_back(len[15:8]);  h.push_back(len[23:16]);
        h.push_back(8'h00);
        h.push_back(id[7:0]);    h.push_back(id[15:8]);
        c = ref_csum(h) ^ (hbad ? 32'h0000_0001 : 32'h0);
        foreach (h[i]) fifo.push_back(h[i]);
        for (int k = 0; k < 4; k++) fifo.push_back(c[8*k +: 8]);
        c = ref_csum(body) ^ (bbad ? 32'h0100_0000 : 32'h0);
        foreach (body[i]) fifo.push_back(body[i]);
        for (int k = 0; k < 4; k++) fifo.push_back(c[8*k +: 8]);
    endtask

    task automatic expect_pkt(input logic [7:0] typ, input logic [15:0] id, input bq_t body, input bit bbad);
        exp_type.push_back(typ);
        exp_id.push_back(id);
        exp_len.push_back(24'(body.size()));
        exp_bad.push_back(CSUM_EN && bbad);
        foreach (body[i]) begin
            exp_sink.push_back(int'(typ) - 1);
            exp_byte.push_back(body[i]);
        end
    endtask

    task automatic send(input logic [7:0] typ, input logic [15:0] id, input bq_t body, input bit bbad);
        push_pkt(8'd2, typ, 24'(body.size()), id, body, 1'b0, bbad);
        expect_pkt(typ, id, body, bbad);
    endtask

    task automatic clear_logs();
        got_sink.delete(); got_byte.delete(); got_type.delete();
        got_id.delete();   got_len.delete();  got_bad.delete();
        exp_sink.delete(); exp_byte.delete(); exp_type.delete();
        exp_id.delete();   exp_len.delete();  exp_bad.delete();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        fifo.delete();
        gap_pct = 0; full_rand = 1'b0; full_force = 3'b000;
        #1;
        chk("reset_ctl", {rd_en, dout, wr_en, pkt_start, pkt_end, pkt_bad, error, pkt_comm_status}, 64'd0);
        chk("reset_hdr", {pkt_type, pkt_id, pkt_len}, 64'd0);
        repeat (3) @(negedge CLK);
        clear_logs();
        #2;
        RST_N = 1'b1;
    endtask

    task automatic wait_drain(input string nm);
        int i;
        for (i = 0; i < 5000; i++) begin
            @(negedge CLK);
            if (fifo.size() == 0 && !pend_pop) break;
        end
        chk({nm, "_drained"}, 64'(i < 5000), 64'd1);
        repeat (6) @(negedge CLK);
    endtask

    task automatic wait_writes(input string nm, input int n);
        int i;
        for (i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (got_sink.size() >= n) break;
        end
        chk({nm, "_reached"}, 64'(got_sink.size() >= n), 64'd1);
    endtask

    task automatic compare_logs(input string nm);
        chk({nm, "_nstart"}, 64'(got_type.size()), 64'(exp_type.size()));
        for (int i = 0; i < got_type.size() && i < exp_type.size(); i++) begin
            chk({nm, "_type"}, 64'(got_type[i]), 64'(exp_type[i]));
            chk({nm, "_id"},   64'(got_id[i]),   64'(exp_id[i]));
            chk({nm, "_len"},  64'(got_len[i]),  64'(exp_len[i]));
        end
        chk({nm, "_nend"}, 64'(got_bad.size()), 64'(exp_bad.size()));
        for (int i = 0; i < got_bad.size() && i < exp_bad.size(); i++)
            chk({nm, "_bad"}, 64'(got_bad[i]), 64'(exp_bad[i]));
        chk({nm, "_nbytes"}, 64'(got_sink.size()), 64'(exp_sink.size()));
        for (int i = 0; i < got_sink.size() && i < exp_sink.size(); i++) begin
            chk({nm, "_sink"}, 64'(got_sink[i]), 64'(exp_sink[i]));
            chk({nm, "_byte"}, 64'(got_byte[i]), 64'(exp_byte[i]));
        end
        clear_logs();
    endtask

    typedef struct {
        logic [7:0]  ver;
        logic [7:0]  typ;
        logic [23:0] len;
        logic [7:0]  exp_status;
        bit          exp_err;
    } hv_t;

    hv_t tbl[8];

    initial begin
        bq_t body;
        bq_t body2;
        string pw;
        bit any_bad;

        #1 RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        chk("init_ctl", {rd_en, dout, wr_en, pkt_start, pkt_end, pkt_bad, error, pkt_comm_status}, 64'd0);
        chk("init_hdr", {pkt_type, pkt_id, pkt_len}, 64'd0);
        #2 RST_N = 1'b1;

        // Header validation vectors
        tbl[0] = '{8'd2, 8'd3, 24'd15,    8'h00, 1'b0};
        tbl[1] = '{8'd1, 8'd3, 24'd15,    8'h01, 1'b1};
        tbl[2] = '{8'd2, 8'd0, 24'd5,     8'h02, 1'b1};
        tbl[3] = '{8'd2, 8'd4, 24'd5,     8'h02, 1'b1};
        tbl[4] = '{8'd2, 8'd1, 24'd0,     8'h04, 1'b1};
        tbl[5] = '{8'd2, 8'd2, 24'd65537, 8'h04, 1'b1};
        tbl[6] = '{8'd1, 8'd0, 24'd5,     8'h03, 1'b1};
        tbl[7] = '{8'd3, 8'd7, 24'd0,     8'h07, 1'b1};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            if (tbl[i].exp_err) begin
                // 10 header bytes are consumed, the remaining 14 must stay in the FIFO
                push_pkt(tbl[i].ver, tbl[i].typ, tbl[i].len, 16'h1234, rand_body(6), 1'b0, 1'b0);
                repeat (40) @(negedge CLK);
                chk("tbl_status",  64'(pkt_comm_status), 64'(tbl[i].exp_status));
                chk("tbl_error",   64'(error), 64'd1);
                chk("tbl_rd_en",   64'(rd_en), 64'd0);
                chk("tbl_left",    64'(fifo.size()), 64'd14);
                chk("tbl_nwrites", 64'(got_sink.size()), 64'd0);
                chk("tbl_nstart",  64'(got_type.size()), 64'd0);
                clear_logs();
            end else begin
                body = rand_body(int'(tbl[i].len));
                send(tbl[i].typ, 16'hCDAB, body, 1'b0);
                wait_drain("tbl_good");
                compare_logs("tbl_good");
                chk("tbl_status", 64'(pkt_comm_status), 64'(tbl[i].exp_status));
                chk("tbl_error",  64'(error), 64'd0);
            end
        end

        // Corrupted header checksum: fatal only when checksums are checked
        do_reset();
        body = rand_body(4);
        push_pkt(8'd2, 8'(PKT_TYPE_WORD_LIST), 24'd4, 16'h55AA, body, 1'b1, 1'b0);
        if (!CSUM_EN) expect_pkt(8'(PKT_TYPE_WORD_LIST), 16'h55AA, body, 1'b0);
        repeat (60) @(negedge CLK);
        compare_logs("hcsum");
        chk("hcsum_status", 64'(pkt_comm_status), CSUM_EN ? 64'h08 : 64'h00);
        chk("hcsum_error",  64'(error), 64'(CSUM_EN));

        // Sink back-pressure: word_gen sink full for 50 cycles after byte 2
        do_reset();
        send(8'(PKT_TYPE_WORD_GEN), 16'h0102, rand_body(6), 1'b0);
        wait_writes("full", 2);
        full_force = 3'b010;
        in_win = 1'b1;
        win_writes = 0;
        repeat (50) @(negedge CLK);
        full_force = 3'b000;
        in_win = 1'b0;
        chk("full_win_writes_le1", 64'(win_writes <= 1), 64'd1);
        wait_drain("full");
        compare_logs("full");

        // Bad body checksum followed by a good packet
        do_reset();
        send(8'(PKT_TYPE_WORD_LIST), 16'hBEEF, rand_body(10), 1'b1);
        send(8'(PKT_TYPE_WORD_LIST), 16'hF00D, rand_body(5), 1'b0);
        wait_drain("bcsum");
        compare_logs("bcsum");
        chk("bcsum_status", 64'(pkt_comm_status), CSUM_EN ? 64'h10 : 64'h00);
        chk("bcsum_error",  64'(error), 64'd0);

        // Reset in the middle of a body, then a fresh packet
        do_reset();
        push_pkt(8'd2, 8'(PKT_TYPE_WORD_LIST), 24'd8, 16'h7777, rand_body(8), 1'b0, 1'b0);
        wait_writes("midrst", 3);
        repeat (3) @(negedge CLK);
        #2;
        RST_N = 1'b0;
        fifo.delete();
        #1;
        chk("midrst_ctl", {rd_en, dout, wr_en, pkt_start, pkt_end, pkt_bad, error, pkt_comm_status}, 64'd0);
        chk("midrst_hdr", {pkt_type, pkt_id, pkt_len}, 64'd0);
        chk("midrst_partial", 64'(got_sink.size() < 8), 64'd1);
        repeat (2) @(negedge CLK);
        clear_logs();
        #2;
        RST_N = 1'b1;
        pw = "mypwd123";
        body.delete();
        for (int i = 0; i < pw.len(); i++) body.push_back(pw[i]);
        send(8'(PKT_TYPE_WORD_LIST), 16'h0042, body, 1'b0);
        wait_drain("midrst");
        compare_logs("midrst");
        chk("midrst_status", 64'(pkt_comm_status), 64'd0);

        // word_gen then word_list back-to-back with random FIFO gaps
        do_reset();
        gap_pct = 30;
        body  = rand_body(9);
        body2 = rand_body(7);
        send(8'(PKT_TYPE_WORD_GEN),  16'h2222, body,  1'b0);
        send(8'(PKT_TYPE_WORD_LIST), 16'h1111, body2, 1'b0);
        wait_drain("b2b");
        compare_logs("b2b");

        // Randomized packets with random gaps and random sink back-pressure
        do_reset();
        gap_pct = 20;
        full_rand = 1'b1;
        any_bad = 1'b0;
        for (int p = 0; p < 10; p++) begin
            bit bb;
            bb = ($urandom_range(0, 3) == 0);
            any_bad = any_bad | bb;
            send(8'($urandom_range(1, 3)), 16'($urandom), rand_body($urandom_range(1, 24)), bb);
        end
        wait_drain("rand");
        full_rand = 1'b0;
        compare_logs("rand");
        chk("rand_status", 64'(pkt_comm_status), (CSUM_EN && any_bad) ? 64'h10 : 64'h00);
        chk("rand_error",  64'(error), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
